// File: rtl/alarm_clock_ctrl.sv
// Mode controller and enable sequencer for the alarm clock counter bank.
// Walks the clock-set / alarm-set modes, gates counter enables and runs the alarm ring timer.
module alarm_clock_ctrl #(
   parameter int unsigned ALARM_LEN = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       btn_c,
   input  logic       btn_l,
   input  logic       btn_r,
   input  logic       btn_u,
   input  logic       btn_d,
   input  logic       sec_max,
   input  logic       min_max,
   input  logic       time_match,
   output logic       sec_en,
   output logic       min_en,
   output logic       hr_en,
   output logic       alm_min_en,
   output logic       alm_hr_en,
   output logic       updown,
   output logic [2:0] mode,
   output logic       adjust,
   output logic       alarm_on,
   output logic       blink
);

   localparam int unsigned CntW = $clog2(ALARM_LEN + 1);
   localparam logic [CntW-1:0] RingLast = CntW'(ALARM_LEN - 1);

   typedef enum logic [2:0] {
      StRun       = 3'd0,
      StAdjClkHr  = 3'd1,
      StAdjClkMin = 3'd2,
      StAdjAlmHr  = 3'd3,
      StAdjAlmMin = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic              alarm_on_q, alarm_on_d;
   logic              blink_q, blink_d;
   logic              match_q;
   logic [CntW-1:0]   ring_cnt_q, ring_cnt_d;

   logic btn_any, live, go_c, go_fwd, go_back, step;

   // While ringing, every button pulse is spent on the dismiss.
   assign btn_any = btn_c | btn_l | btn_r | btn_u | btn_d;
   assign live    = ~alarm_on_q;
   assign go_c    = live & btn_c;
   assign go_fwd  = live & btn_r & ~btn_l;
   assign go_back = live & btn_l & ~btn_r;
   assign step    = live & (btn_u ^ btn_d);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StRun;
         alarm_on_q <= 1'b0;
         blink_q    <= 1'b0;
         match_q    <= 1'b0;
         ring_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         alarm_on_q <= alarm_on_d;
         blink_q    <= blink_d;
         match_q    <= time_match;
         ring_cnt_q <= ring_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun:       if (go_c) state_d = StAdjClkHr;
         StAdjClkHr:  if (go_c) state_d = StRun;
                      else if (go_fwd) state_d = StAdjClkMin;
                      else if (go_back) state_d = StAdjAlmMin;
         StAdjClkMin: if (go_c) state_d = StRun;
                      else if (go_fwd) state_d = StAdjAlmHr;
                      else if (go_back) state_d = StAdjClkHr;
         StAdjAlmHr:  if (go_c) state_d = StRun;
                      else if (go_fwd) state_d = StAdjAlmMin;
                      else if (go_back) state_d = StAdjClkMin;
         StAdjAlmMin: if (go_c) state_d = StRun;
                      else if (go_fwd) state_d = StAdjClkHr;
                      else if (go_back) state_d = StAdjAlmHr;
         default:     state_d = StRun;
      endcase

      alarm_on_d = alarm_on_q;
      ring_cnt_d = ring_cnt_q;
      if (alarm_on_q) begin
         if (btn_any) begin
            alarm_on_d = 1'b0;
         end else if (tick_1hz) begin
            ring_cnt_d = ring_cnt_q + 1'b1;
            if (ring_cnt_q == RingLast) alarm_on_d = 1'b0;
         end
      end else if (state_q == StRun && time_match && !match_q) begin
         alarm_on_d = 1'b1;
         ring_cnt_d = '0;
      end

      if (state_q == StRun || state_d == StRun) blink_d = 1'b0;
      else if (tick_1hz)                        blink_d = ~blink_q;
      else                                      blink_d = blink_q;
   end

   always_comb begin
      sec_en     = 1'b0;
      min_en     = 1'b0;
      hr_en      = 1'b0;
      alm_min_en = 1'b0;
      alm_hr_en  = 1'b0;
      updown     = 1'b1;
      case (state_q)
         StRun: begin
            sec_en = tick_1hz;
            min_en = tick_1hz & sec_max;
            hr_en  = tick_1hz & sec_max & min_max;
         end
         StAdjClkHr:  hr_en      = step;
         StAdjClkMin: min_en     = step;
         StAdjAlmHr:  alm_hr_en  = step;
         StAdjAlmMin: alm_min_en = step;
         default: ;
      endcase
      if (state_q != StRun && step) updown = btn_u;
      mode     = state_q;
      adjust   = (state_q != StRun);
      alarm_on = alarm_on_q;
      blink    = blink_q;
   end

endmodule
